uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   8N1 UART transmitter driving the usb_tx pin from a byte-wide valid/busy interface.
//   Replaces the raw usb_rx->usb_tx echo in the top level.
//   Internal logic now sources serial data toward the USB->Serial bridge.
//   Sits beside the future uart_rx; both run on the 100MHz clk and share the conditioned rst.
// PARAMETERS
//   CLK_RATE      100_000_000  clk frequency in Hz
//   BAUD          1_000_000    line rate in bit/s
//   CLKS_PER_BIT  CLK_RATE/BAUD  derived localparam (100 at defaults); must be >= 2
// PORTS
//   clk       in   1  system clock, 100MHz
//   rst       in   1  reset, synchronous, active-high (from reset_conditioner)
//   data      in   8  byte to send, sampled on the accept cycle
//   new_data  in   1  request to send data
//   block     in   1  high = do not start a new frame (flow control); current frame completes
//   busy      out  1  high = new_data will be ignored this cycle
//   tx        out  1  serial line, idle high
// BEHAVIOUR
//   Reset (rst high at a clk edge): state=IDLE, tx=1, busy=0 from the next cycle.
//     Any frame in flight aborts; no partial stop bit.
//   busy is combinational: (state != IDLE) | block.
//   Accept: new_data & ~busy at a clk edge. data is latched into the shift register.
//     The next state is START; tx falls on the cycle after accept (1-cycle latency).
//   new_data while busy: ignored, byte dropped, no side effect.
//   States:
//     IDLE  : tx=1
//     START : tx=0 for CLKS_PER_BIT cycles
//     DATA  : 8 bits LSB first, each held CLKS_PER_BIT cycles
//     [PARITY]
//     STOP  : tx=1 for CLKS_PER_BIT cycles, then IDLE
//   Counters:
//     ctr   $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1, clears on each state/bit change.
//     bit_ctr 3 bits; advances on ctr wrap in DATA; DATA->next state when bit_ctr==7 and ctr wraps.
//   Frame length: 10*CLKS_PER_BIT cycles (11 with parity).
//     Minimum inter-frame gap is one IDLE cycle: busy is low for that cycle.
//   block rising mid-frame: no effect on tx; frame finishes; IDLE holds until block falls.
//   Simultaneous rst & new_data: rst wins; the byte is not accepted.
//   tx is a registered output (no glitches on the pin).
// CONFIGURATION
//   `UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP.
//     tx = ^data (even parity) for CLKS_PER_BIT cycles.
//   Undefined: no PARITY state; frame is 8N1.
//   Parity is compile-time only, with no port change.
// STRUCTURE
//   uart_pkg: state enum tx_state_t {IDLE, START, DATA, PARITY, STOP}, localparam DATA_BITS=8.
//     Shared with uart_rx.
//   No sub-module: the bit-timing counter is inline. A one-process FSM plus a registered datapath
//     is sufficient.
// TESTING (CLKS_PER_BIT=100 unless noted)
//   1. Reset, then idle 50 cycles -> tx=1, busy=0 throughout.
//   2. Send 0x55 -> tx=0 for 100 cycles, then bits 1,0,1,0,1,0,1,0 at 100 cycles each,
//      then stop=1 for 100 cycles. busy is high for exactly 1000 cycles.
//   3. Send 0xA3, then pulse new_data with 0xFF at cycle 300 -> only the 0xA3 frame appears;
//      the line idles after its stop bit.
//   4. Hold block=1, then pulse new_data with 0x12 -> busy=1, tx stays 1.
//      Release block and resend -> a 0x12 frame starts 1 cycle after accept.
//   5. Assert rst at cycle 450 of a 0x00 frame -> tx=1 and busy=0 on the next cycle.
//      A send 2 cycles later produces a clean full frame.
//   6. `UART_TX_PARITY_EN` defined, send 0x07 -> parity bit 1, frame 1100 cycles.
//      Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: transmitter state encoding and data width.
// Used by uart_tx and the companion uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-wide request/busy handshake plus the serial pin of the UART transmitter.
// master = byte source, slave = transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 new_data;
  logic                 block;
  logic                 busy;
  logic                 tx;

  modport master (
    output data,
    output new_data,
    output block,
    input  busy,
    input  tx
  );

  modport slave (
    input  data,
    input  new_data,
    input  block,
    output busy,
    output tx
  );

endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered tx pin and block flow control.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_RATE = 100_000_000,
  parameter int BAUD     = 1_000_000
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
  localparam int CTR_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);

  tx_state_t            r_state;
  tx_state_t            w_state_nx;
  logic [CTR_W-1:0]     r_ctr;
  logic [CTR_W-1:0]     w_ctr_nx;
  logic [BIT_W-1:0]     r_bit;
  logic [BIT_W-1:0]     w_bit_nx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic                 r_tx;
  logic                 w_tx_nx;
  logic                 w_wrap;
  logic                 w_accept;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif

  assign w_wrap   = (r_ctr == CTR_MAX);
  assign bus.busy = (r_state != IDLE) | bus.block;
  assign w_accept = bus.new_data & ~bus.busy;
  assign bus.tx   = r_tx;

  always_comb begin
    w_state_nx = r_state;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_ctr_nx   = (r_state == IDLE || w_wrap) ? '0 : r_ctr + 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx = START;
          w_shift_nx = bus.data;
          w_bit_nx   = '0;
        end
      end
      START: begin
        if (w_wrap) w_state_nx = DATA;
      end
      DATA: begin
        if (w_wrap) begin
          w_shift_nx = r_shift >> 1;
          w_bit_nx   = r_bit + 1'b1;
          if (r_bit == BIT_MAX) begin
`ifdef UART_TX_PARITY_EN
            w_state_nx = PARITY;
`else
            w_state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_wrap) w_state_nx = STOP;
      end
`endif
      STOP: begin
        if (w_wrap) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // tx is computed from the next state so the pin moves on the same edge
  always_comb begin
    w_tx_nx = 1'b1;
    unique case (w_state_nx)
      START:   w_tx_nx = 1'b0;
      DATA:    w_tx_nx = w_shift_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nx = r_par;
`endif
      default: w_tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ctr   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_ctr   <= w_ctr_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)           r_par <= 1'b0;
    else if (w_accept) r_par <= ^bus.data;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frames compared cycle by cycle
// against a slot-based model of the serial line.
module tb_uart_tx;

  localparam int CPB = 100;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int SLOTS = PAR ? 11 : 10;
  localparam int FRAME = SLOTS * CPB;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_RATE(100_000_000),
    .BAUD    (1_000_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] b);
    bus.data     = b;
    bus.new_data = 1'b1;
    @(posedge clk);
    #1 bus.new_data = 1'b0;
  endtask

  // samples cycles k0..k1-1 of a frame, counts tx/busy deviations
  task automatic run_frame(input logic [7:0] b, input int k0,
                           input int k1, output int bad);
    bad = 0;
    for (int k = k0; k < k1; k++) begin
      @(negedge clk);
      if (bus.tx !== exp_bit(b, k)) bad++;
      if (bus.busy !== 1'b1) bad++;
    end
  endtask

  task automatic idle_check(input int n, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: tx=%b busy=%b, required tx=1 busy=0",
               bus.tx, bus.busy);
    end
    idle_check(50, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_frame_55;
    int bad;
    @(negedge clk);
    send(8'h55);
    @(negedge clk);
    n_chk++;
    if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: tx=%b busy=%b, required tx=0 busy=1",
               bus.tx, bus.busy);
    end
    run_frame(8'h55, 1, FRAME, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL frame_55: %0d bad samples, required 0", bad);
    end
    @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_55: busy=%b tx=%b, required busy=0 tx=1",
               bus.busy, bus.tx);
    end
  endtask

  task automatic test_drop;
    int bad;
    int bad2;
    int bad3;
    int bad4;
    @(negedge clk);
    send(8'hA3);
    run_frame(8'hA3, 0, 300, bad);
    bus.data     = 8'hFF;
    bus.new_data = 1'b1;
    run_frame(8'hA3, 300, 301, bad2);
    bus.new_data = 1'b0;
    run_frame(8'hA3, 301, FRAME, bad3);
    n_chk++;
    if (bad + bad2 + bad3 !== 0) begin
      n_fail++;
      $display("FAIL frame_a3_drop: %0d bad samples, required 0",
               bad + bad2 + bad3);
    end
    idle_check(200, bad4);
    n_chk++;
    if (bad4 !== 0) begin
      n_fail++;
      $display("FAIL idle_after_drop: %0d bad cycles, required 0", bad4);
    end
  endtask

  task automatic test_block;
    int bad;
    @(negedge clk);
    bus.block = 1'b1;
    #1;
    n_chk++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL block_busy: busy=%b, required 1", bus.busy);
    end
    send(8'h12);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b1) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL block_hold: %0d bad cycles, required 0", bad);
    end
    bus.block = 1'b0;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL block_release: busy=%b, required 0", bus.busy);
    end
    send(8'h12);
    @(negedge clk);
    n_chk++;
    if (bus.tx !== 1'b0) begin
      n_fail++;
      $display("FAIL block_start: tx=%b, required 0", bus.tx);
    end
    run_frame(8'h12, 1, FRAME, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL frame_12: %0d bad samples, required 0", bad);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    logic [7:0] b;
    @(negedge clk);
    send(8'h00);
    run_frame(8'h00, 0, 450, bad);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: tx=%b busy=%b, required tx=1 busy=0",
               bus.tx, bus.busy);
    end
    @(negedge clk);
    @(negedge clk);
    b = 8'($urandom);
    send(b);
    run_frame(b, 0, FRAME, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL frame_after_reset: byte %h, %0d bad samples, required 0",
               b, bad);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    logic [7:0] b;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      n_chk++;
      if (bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_gap_%0d: busy=%b, required 0", i, bus.busy);
      end
      send(b);
      run_frame(b, 0, FRAME, bad);
      n_chk++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL b2b_frame_%0d: byte %h, %0d bad samples, required 0",
                 i, b, bad);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_parity;
    int bad;
    logic [7:0] tv [2];
    tv[0] = 8'h07;
    tv[1] = 8'h03;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      send(tv[i]);
      run_frame(tv[i], 0, FRAME, bad);
      n_chk++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL parity_frame_%h: %0d bad samples, required 0",
                 tv[i], bad);
      end
      @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL parity_len_%h: busy=%b after %0d cycles, required 0",
                 tv[i], bus.busy, FRAME);
      end
    end
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.data     = '0;
    bus.new_data = 1'b0;
    bus.block    = 1'b0;
    test_reset();
    test_frame_55();
    test_drop();
    test_block();
    test_reset_mid();
    test_back_to_back();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
